// File: rtl/combine_multi.sv
// ============================================================================
// combine_multi
// ----------------------------------------------------------------------------
// Pixel compositor that sits between the VGA controller and the palette
// lookup. It reads packed colour enums from an internal frame buffer
// (synchronous-read RAM), overlays N_PLAYERS bike sprites with fixed priority
// (the lowest index wins), and reports per-player head collisions against
// non-background trail pixels once per frame.
//
// Ports
//   Clk            system clock
//   Reset          asynchronous, active-low reset
//   frame_clk      frame strobe (level); its rising edge publishes collisions
//   DrawX, DrawY   current pixel coordinates
//   pix_in_valid   DrawX/DrawY lie in the visible area this cycle
//   WE             frame-buffer write enable
//   write_address  frame-buffer word address
//   Data_In        frame-buffer write word (PIX_PER_WORD packed enums)
//   bike_pix       per-player sprite enum at the current pixel
//   bike_head      per-player head-pixel flag
//   color_enum     composited enum, 2 cycles after the inputs
//   pix_out_valid  color_enum is valid
//   collide        per-player collision flags for the last completed frame
//   collide_enum   per-player enum hit first in that frame
// ============================================================================
module combine_multi #(
    parameter int                  H_RES        = 640,
    parameter int                  V_RES        = 480,
    parameter int                  PIX_BITS     = 4,
    parameter int                  PIX_PER_WORD = 2,
    parameter int                  N_PLAYERS    = 2,
    parameter logic [PIX_BITS-1:0] TRANSPARENT  = 4'hF,
    parameter logic [PIX_BITS-1:0] BG_ENUM      = 4'h0
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_clk,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            pix_in_valid,
    input  logic                            WE,
    input  logic [18:0]                     write_address,
    input  logic [PIX_BITS*PIX_PER_WORD-1:0] Data_In,
    input  logic [N_PLAYERS*PIX_BITS-1:0]   bike_pix,
    input  logic [N_PLAYERS-1:0]            bike_head,
    output logic [PIX_BITS-1:0]             color_enum,
    output logic                            pix_out_valid,
    output logic [N_PLAYERS-1:0]            collide,
    output logic [N_PLAYERS*PIX_BITS-1:0]   collide_enum
);

    localparam int WORD_W   = PIX_BITS * PIX_PER_WORD;
    localparam int DEPTH    = (H_RES * V_RES) / PIX_PER_WORD;
    localparam int AW       = $clog2(DEPTH);
    localparam int LANE_W   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int WPL      = H_RES / PIX_PER_WORD;   // words per line

    // ------------------------------------------------------------------
    // Stage 0: address and lane generation (19-bit unsigned arithmetic)
    // ------------------------------------------------------------------
    logic [18:0]       w_x19;
    logic [18:0]       w_y19;
    logic [18:0]       w_read_addr;
    logic [LANE_W-1:0] w_lane;

    assign w_x19       = {9'd0, DrawX};
    assign w_y19       = {9'd0, DrawY};
    assign w_read_addr = (w_x19 / 19'(PIX_PER_WORD)) + (w_y19 * 19'(WPL));
    assign w_lane      = LANE_W'(w_x19 % 19'(PIX_PER_WORD));

    // ------------------------------------------------------------------
    // Frame buffer: one write port, one registered read port. Read and
    // write in the same block with non-blocking updates gives read-first
    // behaviour, so a same-address collision returns the old word.
    // Out-of-range addresses never write and read back as zero.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_ram_q;

    always_ff @(posedge Clk) begin
        if (WE && (write_address < 19'(DEPTH)))
            r_mem[AW'(write_address)] <= Data_In;
        r_ram_q <= (w_read_addr < 19'(DEPTH)) ? r_mem[AW'(w_read_addr)] : '0;
    end

    // ------------------------------------------------------------------
    // Stage 1 side-band registers, aligned with r_ram_q
    // ------------------------------------------------------------------
    logic                          r_s1_valid;
    logic [LANE_W-1:0]             r_s1_lane;
    logic [N_PLAYERS*PIX_BITS-1:0] r_s1_bike;
    logic [N_PLAYERS-1:0]          r_s1_head;
    logic [PIX_BITS-1:0]           r_color;
    logic                          r_out_valid;
    logic                          r_frame_q;

    logic [PIX_BITS-1:0]           w_fb;
    logic [PIX_BITS-1:0]           w_bike [N_PLAYERS];
    logic [N_PLAYERS-1:0]          w_hit;
    logic [PIX_BITS-1:0]           w_overlay;
    logic                          w_frame_edge;

    assign w_fb         = r_ram_q[r_s1_lane*PIX_BITS +: PIX_BITS];
    assign w_frame_edge = frame_clk & ~r_frame_q;

    // Per-player sprite slice and collision event
    genvar gi;
    generate
        for (gi = 0; gi < N_PLAYERS; gi++) begin : g_player
            assign w_bike[gi] = r_s1_bike[gi*PIX_BITS +: PIX_BITS];
            assign w_hit[gi]  = r_s1_valid & r_s1_head[gi] &
                                (w_bike[gi] != TRANSPARENT) & (w_fb != BG_ENUM);
        end
    endgenerate

    // Walk from the highest index down so the lowest opaque player wins.
    always_comb begin
        w_overlay = w_fb;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (w_bike[i] != TRANSPARENT)
                w_overlay = w_bike[i];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers (stage 1 capture, stage 2 output)
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_lane   <= '0;
            r_s1_bike   <= '0;
            r_s1_head   <= '0;
            r_color     <= BG_ENUM;
            r_out_valid <= 1'b0;
            r_frame_q   <= 1'b0;
        end else begin
            r_s1_valid  <= pix_in_valid;
            r_s1_lane   <= w_lane;
            r_s1_bike   <= bike_pix;
            r_s1_head   <= bike_head;
            r_color     <= r_s1_valid ? w_overlay : BG_ENUM;
            r_out_valid <= r_s1_valid;
            r_frame_q   <= frame_clk;
        end
    end

    // ------------------------------------------------------------------
    // Collision bookkeeping. On a frame edge the pending state is
    // published and restarted from this cycle's hits, so a hit coincident
    // with the edge belongs to the new frame.
    // ------------------------------------------------------------------
    logic [N_PLAYERS-1:0] r_pend_hit;
    logic [PIX_BITS-1:0]  r_pend_enum    [N_PLAYERS];
    logic [N_PLAYERS-1:0] r_collide;
    logic [PIX_BITS-1:0]  r_collide_enum [N_PLAYERS];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pend_hit <= '0;
            r_collide  <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_pend_enum[i]    <= '0;
                r_collide_enum[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (w_frame_edge) begin
                    r_collide[i]      <= r_pend_hit[i];
                    r_collide_enum[i] <= r_pend_enum[i];
                    r_pend_hit[i]     <= w_hit[i];
                    r_pend_enum[i]    <= w_hit[i] ? w_fb : '0;
                end else if (w_hit[i]) begin
                    r_pend_hit[i] <= 1'b1;
                    // Keep only the first hit of the frame
                    if (!r_pend_hit[i])
                        r_pend_enum[i] <= w_fb;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < N_PLAYERS; gi++) begin : g_out
            assign collide_enum[gi*PIX_BITS +: PIX_BITS] = r_collide_enum[gi];
        end
    endgenerate

    assign color_enum    = r_color;
    assign pix_out_valid = r_out_valid;
    assign collide       = r_collide;

endmodule

// File: tb/tb_combine_multi.sv
// ============================================================================
// tb_combine_multi
// ----------------------------------------------------------------------------
// Directed testbench for combine_multi with default parameters (640x480,
// 4-bit enums, 2 enums per word, 2 players). Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// ============================================================================
module tb_combine_multi;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_in_valid;
    logic        WE;
    logic [18:0] write_address;
    logic [7:0]  Data_In;
    logic [7:0]  bike_pix;
    logic [1:0]  bike_head;
    logic [3:0]  color_enum;
    logic        pix_out_valid;
    logic [1:0]  collide;
    logic [7:0]  collide_enum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    combine_multi dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pix_in_valid  (pix_in_valid),
        .WE            (WE),
        .write_address (write_address),
        .Data_In       (Data_In),
        .bike_pix      (bike_pix),
        .bike_head     (bike_head),
        .color_enum    (color_enum),
        .pix_out_valid (pix_out_valid),
        .collide       (collide),
        .collide_enum  (collide_enum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fb_write(input logic [18:0] addr, input logic [7:0] data);
        WE = 1'b1; write_address = addr; Data_In = data;
        @(negedge Clk);
        WE = 1'b0;
        $display("write addr=%0d data=%h", addr, data);
    endtask

    // One isolated pixel: checks it is not out after 1 cycle and is out after 2.
    task automatic drive_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [7:0] bp, input logic [1:0] hd,
                             input logic [3:0] exp);
        DrawX = x; DrawY = y; bike_pix = bp; bike_head = hd; pix_in_valid = 1'b1;
        @(negedge Clk);
        pix_in_valid = 1'b0; bike_pix = 8'hFF; bike_head = 2'b00;
        chk({tag, "_lat1"}, 32'(pix_out_valid), 32'd0);
        @(negedge Clk);
        chk({tag, "_valid"}, 32'(pix_out_valid), 32'd1);
        chk({tag, "_color"}, 32'(color_enum), 32'(exp));
        $display("pix %s x=%0d y=%0d bikes=%h head=%b color=%h", tag, x, y, bp, hd, color_enum);
    endtask

    task automatic frame_pulse();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        $display("frame edge collide=%b collide_enum=%h", collide, collide_enum);
    endtask

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; DrawX = '0; DrawY = '0; pix_in_valid = 1'b0;
        WE = 1'b0; write_address = '0; Data_In = '0; bike_pix = 8'hFF; bike_head = 2'b00;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_color", 32'(color_enum), 32'h0);
        chk("rst_valid", 32'(pix_out_valid), 32'd0);
        chk("rst_collide", 32'(collide), 32'd0);
        chk("rst_cenum", 32'(collide_enum), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // Frame-buffer contents
        fb_write(19'd0, 8'h53);        // x0=3, x1=5
        fb_write(19'd1, 8'h87);        // x2=7, x3=8
        fb_write(19'd2, 8'h00);        // x4=BG, x5=BG
        fb_write(19'd153599, 8'hA6);   // (638,479)=6, (639,479)=A

        // Back-to-back pixels, 2-cycle latency
        DrawX = 10'd0; DrawY = 10'd0; pix_in_valid = 1'b1;
        @(negedge Clk);
        DrawX = 10'd1;
        chk("strm_lat1", 32'(pix_out_valid), 32'd0);
        @(negedge Clk);
        pix_in_valid = 1'b0;
        chk("strm0_valid", 32'(pix_out_valid), 32'd1);
        chk("strm0_color", 32'(color_enum), 32'h3);
        $display("pix strm x=0 color=%h", color_enum);
        @(negedge Clk);
        chk("strm1_valid", 32'(pix_out_valid), 32'd1);
        chk("strm1_color", 32'(color_enum), 32'h5);
        $display("pix strm x=1 color=%h", color_enum);
        @(negedge Clk);
        chk("strm_idle_valid", 32'(pix_out_valid), 32'd0);
        chk("strm_idle_color", 32'(color_enum), 32'h0);

        // Last visible word, both lanes
        drive_pix("last_hi", 10'd639, 10'd479, 8'hFF, 2'b00, 4'hA);
        drive_pix("last_lo", 10'd638, 10'd479, 8'hFF, 2'b00, 4'h6);

        // Overlay priority over fb enum 7
        drive_pix("ovl_both", 10'd2, 10'd0, 8'h53, 2'b00, 4'h3);
        drive_pix("ovl_p1",   10'd2, 10'd0, 8'h5F, 2'b00, 4'h5);
        drive_pix("ovl_none", 10'd2, 10'd0, 8'hFF, 2'b00, 4'h7);

        // Player 1 hits 3, then 8 (ignored); player 0 head over BG
        drive_pix("hit_a",  10'd0, 10'd0, 8'h5F, 2'b10, 4'h5);
        drive_pix("hit_b",  10'd3, 10'd0, 8'h5F, 2'b10, 4'h5);
        drive_pix("hit_bg", 10'd4, 10'd0, 8'hF2, 2'b01, 4'h2);
        chk("pre_edge_collide", 32'(collide), 32'd0);
        frame_pulse();
        chk("edge1_collide", 32'(collide), 32'b10);
        chk("edge1_cenum", 32'(collide_enum), 32'h30);
        frame_pulse();
        chk("edge2_collide", 32'(collide), 32'd0);
        chk("edge2_cenum", 32'(collide_enum), 32'h00);

        // Hit coincident with a frame edge lands in the next frame
        @(negedge Clk);
        DrawX = 10'd0; DrawY = 10'd0; bike_pix = 8'hF1; bike_head = 2'b01; pix_in_valid = 1'b1;
        @(negedge Clk);
        pix_in_valid = 1'b0; bike_pix = 8'hFF; bike_head = 2'b00; frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        chk("coin_color", 32'(color_enum), 32'h1);
        chk("coin_collide", 32'(collide), 32'd0);
        chk("coin_cenum", 32'(collide_enum), 32'h00);
        $display("coincident edge collide=%b collide_enum=%h", collide, collide_enum);
        frame_pulse();
        chk("coin_next_collide", 32'(collide), 32'b01);
        chk("coin_next_cenum", 32'(collide_enum), 32'h03);

        // Reset mid-line with a pending hit and a pixel in flight
        repeat (3) @(negedge Clk);
        chk("hold_collide", 32'(collide), 32'b01);
        DrawX = 10'd3; DrawY = 10'd0; bike_pix = 8'h5F; bike_head = 2'b10; pix_in_valid = 1'b1;
        @(negedge Clk);
        DrawX = 10'd0; bike_pix = 8'hFF; bike_head = 2'b00;
        @(negedge Clk);
        Reset = 1'b0; pix_in_valid = 1'b0;
        #1;
        chk("mrst_color", 32'(color_enum), 32'h0);
        chk("mrst_valid", 32'(pix_out_valid), 32'd0);
        chk("mrst_collide", 32'(collide), 32'd0);
        chk("mrst_cenum", 32'(collide_enum), 32'h00);
        $display("mid-line reset collide=%b valid=%b", collide, pix_out_valid);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mrst_drop_valid", 32'(pix_out_valid), 32'd0);
        frame_pulse();
        chk("mrst_edge_collide", 32'(collide), 32'd0);
        chk("mrst_edge_cenum", 32'(collide_enum), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
